// File: rtl/enet_pkg.sv
// Shared constants and state types for the GPIO sample transport.
//   SAMPLE_W         : width of one GPIO sample word
//   FRAME_LEN        : sample words carried by one Ethernet frame
//   TICKS_PER_SAMPLE : clocks between consecutive samples (capture and replay)
//   wr_state_e       : receive-side write FSM states
//   rd_state_e       : playback read FSM states
package enet_pkg;

  localparam int SAMPLE_W         = 16;
  localparam int FRAME_LEN        = 18;
  localparam int TICKS_PER_SAMPLE = 557;

  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int TICK_W = $clog2(TICKS_PER_SAMPLE);

  typedef enum logic {
    WR_FILL = 1'b0,
    WR_DROP = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_PLAY = 1'b1
  } rd_state_e;

endpackage

// File: rtl/pingpong_bank.sv
// Two-bank frame store with per-bank full flags.
// The write side always fills the bank after the last committed one; the read
// side always plays the bank after the last released one, so frames come out
// in arrival order.
// Ports:
//   CLK, RST_N     : clock, asynchronous active-low reset
//   i_wr_en        : store i_wr_data at the write index of the write bank
//   i_wr_data      : word to store
//   i_wr_last      : stored word carries the end-of-frame mark
//   o_wr_full      : current write bank holds an unplayed frame
//   o_wr_at_end    : write index is on the final word slot
//   i_rd_take      : consume the word at the read index
//   o_rd_data      : word at the read index of the read bank
//   o_rd_full      : current read bank holds a complete frame
//   o_rd_last      : read index is on the final word slot
//   o_rd_at_start  : read index is on word 0 (a new frame is due)
module pingpong_bank
  import enet_pkg::*;
(
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                i_wr_en,
  input  logic [SAMPLE_W-1:0] i_wr_data,
  input  logic                i_wr_last,
  output logic                o_wr_full,
  output logic                o_wr_at_end,
  input  logic                i_rd_take,
  output logic [SAMPLE_W-1:0] o_rd_data,
  output logic                o_rd_full,
  output logic                o_rd_last,
  output logic                o_rd_at_start
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [SAMPLE_W-1:0] r_mem [2][FRAME_LEN];
  logic [1:0]          r_full;
  logic                r_wr_bank;
  logic                r_rd_bank;
  logic [IDX_W-1:0]    r_wr_idx;
  logic [IDX_W-1:0]    r_rd_idx;

  logic                w_commit;
  logic                w_release;
  logic [1:0]          w_full_nxt;

  assign o_wr_full     = r_full[r_wr_bank];
  assign o_wr_at_end   = (r_wr_idx == LAST_IDX);
  assign o_rd_data     = r_mem[r_rd_bank][r_rd_idx];
  assign o_rd_full     = r_full[r_rd_bank];
  assign o_rd_last     = (r_rd_idx == LAST_IDX);
  assign o_rd_at_start = (r_rd_idx == '0);

  assign w_commit  = i_wr_en & i_wr_last & o_wr_at_end;
  assign w_release = i_rd_take & o_rd_last;

  // Commit and release never target the same bank: writes only go to a free
  // bank and releases only come from a full one.
  always_comb begin
    w_full_nxt = r_full;
    if (w_commit)  w_full_nxt[r_wr_bank] = 1'b1;
    if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
  end

  // Sample storage is not reset; a cleared full flag is what discards it.
  always_ff @(posedge CLK) begin
    if (i_wr_en) r_mem[r_wr_bank][r_wr_idx] <= i_wr_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
    end else begin
      r_full <= w_full_nxt;
      // Any end-of-frame mark or a full slot count restarts the write index,
      // whether the frame was good or is being thrown away.
      if (i_wr_en) begin
        if (i_wr_last || o_wr_at_end) r_wr_idx <= '0;
        else                          r_wr_idx <= r_wr_idx + 1'b1;
        if (w_commit) r_wr_bank <= ~r_wr_bank;
      end
      if (i_rd_take) begin
        if (o_rd_last) begin
          r_rd_idx  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_idx  <= r_rd_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sample_frame_player.sv
// Replays received GPIO sample frames on a parallel output at the fixed
// sample cadence. Frames arrive as a valid/ready word stream and are
// double-buffered so the next frame loads while the current one plays.
// Ports:
//   CLK, RST_N    : clock, asynchronous active-low reset
//   in_data       : incoming sample word
//   in_valid      : in_data valid
//   in_last       : final word of a frame (qualified by in_valid)
//   in_ready      : word accepted when in_valid && in_ready
//   gpio_out      : replayed sample, held between strobes
//   sample_strobe : one-cycle pulse when gpio_out takes a new word
//   frame_done    : one-cycle pulse with the last word of a frame
//   underrun      : one-cycle pulse when playback runs out of frames
//   frame_error   : one-cycle pulse when a frame is discarded for bad length
module sample_frame_player
  import enet_pkg::*;
(
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [SAMPLE_W-1:0] gpio_out,
  output logic                sample_strobe,
  output logic                frame_done,
  output logic                underrun,
  output logic                frame_error
);

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_SAMPLE - 1);

  wr_state_e           r_wr_state;
  wr_state_e           w_wr_state_nxt;
  rd_state_e           r_rd_state;
  rd_state_e           w_rd_state_nxt;
  logic [TICK_W-1:0]   r_tick;

  logic [SAMPLE_W-1:0] r_gpio;
  logic                r_strobe;
  logic                r_done;
  logic                r_under;
  logic                r_ferr;

  logic                w_in_ready;
  logic                w_hs;
  logic                w_store;
  logic                w_wr_err;
  logic                w_wr_full;
  logic                w_wr_at_end;
  logic                w_tick_wrap;
  logic                w_take;
  logic                w_under;
  logic [SAMPLE_W-1:0] w_rd_data;
  logic                w_rd_full;
  logic                w_rd_last;
  logic                w_rd_at_start;

  pingpong_bank u_bank (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .i_wr_en       (w_store),
    .i_wr_data     (in_data),
    .i_wr_last     (in_last),
    .o_wr_full     (w_wr_full),
    .o_wr_at_end   (w_wr_at_end),
    .i_rd_take     (w_take),
    .o_rd_data     (w_rd_data),
    .o_rd_full     (w_rd_full),
    .o_rd_last     (w_rd_last),
    .o_rd_at_start (w_rd_at_start)
  );

  // While dropping, words are swallowed regardless of bank state.
  assign w_in_ready  = (r_wr_state == WR_DROP) | ~w_wr_full;
  assign w_hs        = in_valid & w_in_ready;
  assign w_tick_wrap = (r_tick == TICK_MAX);

  assign in_ready      = w_in_ready;
  assign gpio_out      = r_gpio;
  assign sample_strobe = r_strobe;
  assign frame_done    = r_done;
  assign underrun      = r_under;
  assign frame_error   = r_ferr;

  // ---------------- write FSM ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_wr_state <= WR_FILL;
    else        r_wr_state <= w_wr_state_nxt;
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      WR_FILL: if (w_hs && w_wr_at_end && !in_last) w_wr_state_nxt = WR_DROP;
      WR_DROP: if (w_hs && in_last)                 w_wr_state_nxt = WR_FILL;
      default: w_wr_state_nxt = WR_FILL;
    endcase
  end

  // A frame is bad when the end mark and the final slot disagree.
  always_comb begin
    w_store  = 1'b0;
    w_wr_err = 1'b0;
    if (r_wr_state == WR_FILL) begin
      w_store  = w_hs;
      w_wr_err = w_hs & (in_last ^ w_wr_at_end);
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_rd_state <= RD_IDLE;
    else        r_rd_state <= w_rd_state_nxt;
  end

  // In PLAY a read index of 0 means the previous frame has been released and
  // the next boundary needs a freshly full bank.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (w_rd_full) w_rd_state_nxt = RD_PLAY;
      RD_PLAY: if (w_tick_wrap && w_rd_at_start && !w_rd_full)
                 w_rd_state_nxt = RD_IDLE;
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    w_take  = 1'b0;
    w_under = 1'b0;
    case (r_rd_state)
      RD_IDLE: w_take = w_rd_full;
      RD_PLAY: begin
        if (w_tick_wrap) begin
          if (!w_rd_at_start || w_rd_full) w_take  = 1'b1;
          else                             w_under = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Counter sits at 0 while idle so the first boundary after a start is a
  // full sample period away.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                  r_tick <= '0;
    else if (r_rd_state == RD_PLAY && !w_tick_wrap) r_tick <= r_tick + 1'b1;
    else                                         r_tick <= '0;
  end

  // ---------------- output registers ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_gpio   <= '0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      r_under  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      if (w_take) r_gpio <= w_rd_data;
      r_strobe <= w_take;
      r_done   <= w_take & w_rd_last;
      r_under  <= w_under;
      r_ferr   <= w_wr_err;
    end
  end

endmodule

// File: tb/tb_sample_frame_player.sv
// Self-checking bench for sample_frame_player. A behavioural model built from
// frames (queues of words) predicts every replayed word, strobe spacing,
// frame_done placement, underruns and length errors.
module tb_sample_frame_player;

  localparam int SW   = 16;
  localparam int FLEN = 18;
  localparam int TPS  = 557;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [SW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [SW-1:0] gpio_out;
  logic          sample_strobe;
  logic          frame_done;
  logic          underrun;
  logic          frame_error;

  always #5 CLK = ~CLK;

  sample_frame_player dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .gpio_out      (gpio_out),
    .sample_strobe (sample_strobe),
    .frame_done    (frame_done),
    .underrun      (underrun),
    .frame_error   (frame_error)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int exp_q[$];
  int cur_frame[$];
  int frame_buf[24];
  int cyc        = 0;
  int play_pos   = 0;
  int t_strobe   = 0;
  int t_ready    = 0;
  int t_done     = 0;
  int t_first    = 0;
  int last_word  = 0;
  int n_under    = 0;
  int n_err      = 0;
  int n_err_exp  = 0;
  bit playing    = 1'b0;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Observe the outputs produced by the edge just passed.
  task model_step();
    if (!RST_N) return;
    if (sample_strobe) begin
      if (exp_q.size() == 0) chk_eq("spurious_strobe", 1, 0);
      else                   chk_eq("gpio_word", int'(gpio_out), exp_q.pop_front());
      if (playing) chk_eq("strobe_gap", cyc - t_strobe, TPS);
      else         chk_eq("start_latency", cyc, t_ready + 2);
      chk_eq("frame_done", int'(frame_done), int'(play_pos == FLEN - 1));
      if (frame_done) t_done = cyc;
      play_pos  = (play_pos + 1) % FLEN;
      t_strobe  = cyc;
      last_word = int'(gpio_out);
      playing   = 1'b1;
    end else if (frame_done) begin
      chk_eq("done_without_strobe", 1, 0);
    end
    if (underrun) begin
      n_under++;
      chk_eq("underrun_gap", cyc - t_strobe, TPS);
      chk_eq("underrun_queue_empty", exp_q.size(), 0);
      chk_eq("underrun_frame_pos", play_pos, 0);
      chk_eq("underrun_hold", int'(gpio_out), last_word);
      playing = 1'b0;
    end
    if (frame_error) n_err++;
  endtask

  task wait_cyc();
    @(negedge CLK);
    cyc++;
    model_step();
  endtask

  // A frame plays only if it is exactly FLEN words with the mark on the last.
  task accept_word(input int data, input bit last);
    cur_frame.push_back(data);
    if (last) begin
      if (cur_frame.size() == FLEN) begin
        foreach (cur_frame[i]) exp_q.push_back(cur_frame[i]);
        t_ready = cyc;
      end else begin
        n_err_exp++;
      end
      cur_frame.delete();
    end
  endtask

  task send_word(input int data, input bit last);
    bit done;
    done     = 1'b0;
    in_data  = SW'(data);
    in_last  = last;
    in_valid = 1'b1;
    for (int w = 0; w < 20000; w++) begin
      if (in_ready) begin
        accept_word(data, last);
        t_first = (cur_frame.size() == 1) ? cyc : t_first;
        wait_cyc();
        done = 1'b1;
        break;
      end
      wait_cyc();
    end
    if (!done) chk_eq("ready_timeout", 0, 1);
  endtask

  task send_frame(input int len, input int gap_max);
    for (int i = 0; i < len; i++) begin
      send_word(frame_buf[i], i == len - 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat ($urandom_range(gap_max, 0)) wait_cyc();
    end
  endtask

  task fill_seq(input int base);
    for (int i = 0; i < 24; i++) frame_buf[i] = base + i;
  endtask

  task fill_rand();
    for (int i = 0; i < 24; i++) frame_buf[i] = int'($urandom_range(16'hFFFF, 0));
  endtask

  task wait_underruns(input int target, input int budget);
    for (int i = 0; i < budget && n_under < target; i++) wait_cyc();
    chk_eq("underrun_count", n_under, target);
  endtask

  task check_reset_outputs(input string tag);
    chk_eq({tag, "_gpio"},      int'(gpio_out), 0);
    chk_eq({tag, "_strobe"},    int'(sample_strobe), 0);
    chk_eq({tag, "_done"},      int'(frame_done), 0);
    chk_eq({tag, "_underrun"},  int'(underrun), 0);
    chk_eq({tag, "_frame_err"}, int'(frame_error), 0);
    chk_eq({tag, "_in_ready"},  int'(in_ready), 1);
  endtask

  initial begin
    RST_N    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST_N = 1'b1;
    wait_cyc();

    // Single frame 0..17, second frame 100..117 loaded mid-playback.
    fill_seq(0);
    send_frame(FLEN, 2);
    repeat (3000) wait_cyc();
    fill_seq(100);
    send_frame(FLEN, 1);
    wait_underruns(1, 25000);
    chk_eq("hold_after_underrun", int'(gpio_out), 117);

    // Three frames offered back-to-back: third must wait for a free bank.
    fill_rand();
    send_frame(FLEN, 0);
    fill_rand();
    send_frame(FLEN, 0);
    chk_eq("ready_low_both_full", int'(in_ready), 0);
    fill_rand();
    send_frame(FLEN, 0);
    chk_eq("ready_after_done", t_first, t_done);
    wait_underruns(2, 35000);

    // Short frame, then overlong frame, then a good one.
    fill_rand();
    send_frame(4, 1);
    fill_rand();
    send_frame(20, 1);
    chk_eq("error_count_bad", n_err, n_err_exp);
    fill_rand();
    send_frame(FLEN, 1);
    wait_underruns(3, 15000);
    chk_eq("error_count_after_good", n_err, 2);

    // Reset while word 9 is showing, then a fresh frame.
    fill_rand();
    send_frame(FLEN, 1);
    for (int i = 0; i < 8000 && play_pos != 10; i++) wait_cyc();
    chk_eq("reached_word9", play_pos, 10);
    repeat (50) wait_cyc();
    RST_N = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    cur_frame.delete();
    play_pos = 0;
    playing  = 1'b0;
    repeat (3) wait_cyc();
    RST_N = 1'b1;
    wait_cyc();
    fill_seq(200);
    send_frame(FLEN, 1);
    wait_underruns(4, 15000);
    chk_eq("hold_after_reset_frame", int'(gpio_out), 217);
    chk_eq("final_queue_empty", exp_q.size(), 0);
    chk_eq("final_error_count", n_err, n_err_exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
